// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the RV32I core. It also holds the load-use
// hazard detector and the stall/flush event counters.
//
// Each rising edge does one of four things, in priority order:
//   ex_flush : load a bubble. EX is cleared and the taken branch squashes
//              the younger slot.
//   hold     : keep every ex_* register. MEM is busy.
//   hazard   : load a bubble. The load in EX has not produced its data yet,
//              so the dependent instruction waits in ID.
//   default  : capture the ID fields.
//
// Ports
//   clk, reset            clock, async active-high reset
//   id_valid, id_pc       ID slot valid / PC
//   id_rs1/rs2/rd         register indices
//   id_use_rs1/rs2        instruction really reads rs1 / rs2
//   id_rs1/rs2_dout       register-file read data
//   id_imm                sign-extended immediate
//   id_ctrl[9:0]          {reg_write, mem_read, mem_write, mem_to_reg,
//                          alu_src, branch, alu_op[3:0]}
//   ex_flush              branch taken in EX this cycle
//   hold                  downstream busy, freeze this register
//   stall                 combinational, freezes PC and IF/ID
//   ex_*                  registered copies of the id_* fields
//   stall_cnt, flush_cnt  saturating event counters
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int REG_WIDTH = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 id_valid,
    input  logic [PC_WIDTH-1:0]  id_pc,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_WIDTH-1:0] id_rs1_dout,
    input  logic [REG_WIDTH-1:0] id_rs2_dout,
    input  logic [REG_WIDTH-1:0] id_imm,
    input  logic [9:0]           id_ctrl,

    input  logic                 ex_flush,
    input  logic                 hold,

    output logic                 stall,

    output logic                 ex_valid,
    output logic [PC_WIDTH-1:0]  ex_pc,
    output logic [4:0]           ex_rs1,
    output logic [4:0]           ex_rs2,
    output logic [4:0]           ex_rd,
    output logic [REG_WIDTH-1:0] ex_rs1_dout,
    output logic [REG_WIDTH-1:0] ex_rs2_dout,
    output logic [REG_WIDTH-1:0] ex_imm,
    output logic [9:0]           ex_ctrl,

    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    // Bit positions inside the control bundle.
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_BRANCH     = 4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    // -----------------------------------------------------------------------
    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;
    logic hazard;

    // A load that targets x0 never produces a value anyone waits for.
    assign ex_is_load = ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rd != 5'd0);

    // An operand the instruction does not read cannot create a dependency.
    assign rs1_match  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_match  = id_use_rs2 & (id_rs2 == ex_rd);

    assign hazard     = ex_is_load & id_valid & (rs1_match | rs2_match);

    // A flush squashes ID anyway, so freezing upstream would only waste a
    // cycle. A hold also freezes upstream, which keeps IF/ID aligned with EX.
    assign stall      = (hazard | hold) & ~ex_flush;

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    logic load_bubble;   // EX gets an empty slot (flush or hazard)
    logic capture;       // EX takes the ID contents
    logic hazard_bubble; // bubble caused by the load-use hazard alone

    assign load_bubble   = ex_flush | (~hold & hazard);
    assign capture       = ~ex_flush & ~hold & ~hazard;
    assign hazard_bubble = ~ex_flush & ~hold & hazard;

    // -----------------------------------------------------------------------
    // Pipeline register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_dout <= '0;
            ex_rs2_dout <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
        end else if (load_bubble) begin
            // Data fields are don't-care in a bubble. They are zeroed so
            // that stale operands never appear on the EX buses.
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_dout <= '0;
            ex_rs2_dout <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
        end else if (capture) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_dout <= id_rs1_dout;
            ex_rs2_dout <= id_rs2_dout;
            ex_imm      <= id_imm;
            // An invalid slot must not carry side effects (reg_write,
            // mem_write, branch) into EX.
            ex_ctrl     <= id_valid ? id_ctrl : 10'd0;
        end
        // The remaining case is hold, and every register keeps its value.
    end

    // -----------------------------------------------------------------------
    // Event counters (saturating)
    // -----------------------------------------------------------------------
    // Stalls caused only by hold are MEM's cost, not a load-use penalty, so
    // only bubbles created by the hazard are counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hazard_bubble && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Every flush is counted, even one that squashes an empty slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (ex_flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    // The named control bits document the bundle layout. Only mem_read is
    // used in this stage.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{ex_ctrl[CTRL_REG_WRITE], ex_ctrl[CTRL_MEM_WRITE],
                                ex_ctrl[CTRL_MEM_TO_REG], ex_ctrl[CTRL_ALU_SRC],
                                ex_ctrl[CTRL_BRANCH]};

endmodule
